// File: rtl/decoder_pkg.sv
// Shared state encoding and output-width helper for the decoder_scan block.
// No timing of its own; no flow control.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    function automatic int onehot_w(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/scan_tick.sv
// Scan pacing: divider counting 0..TICK_DIV-1 and the index advance it triggers.
// idx_next/step are combinational from the divider register; no backpressure.
module scan_tick
    import decoder_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int ADDR_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [ADDR_W-1:0] idx,
    output logic [ADDR_W-1:0] idx_next,
    output logic              step
);

    localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tc;

    // run is low on the scan entry cycle, so the divider starts from 0 there
    assign tc       = run && (div_q == DIV_LAST);
    assign step     = tc;
    assign idx_next = tc ? idx + ADDR_W'(1) : idx;

    always_comb begin
        div_d = '0;
        if (run && !tc) begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot/one-cold decoder with direct load; auto-scan only when DECODER_SCAN_EN is defined.
// z/idx/step update 1 cycle after the controlling inputs; no backpressure, inputs sampled every cycle.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int ADDR_W   = 3,
    parameter int TICK_DIV = 4,
    parameter int ACT_HIGH = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   mode,
    input  logic                   load,
    input  logic [ADDR_W-1:0]      addr,
    output logic [(1<<ADDR_W)-1:0] z,
    output logic [ADDR_W-1:0]      idx,
    output logic                   step
);

    localparam int               OUT_W  = onehot_w(ADDR_W);
    localparam logic [OUT_W-1:0] Z_IDLE = (ACT_HIGH != 0) ? '0 : '1;

    function automatic logic [OUT_W-1:0] decode(input logic [ADDR_W-1:0] a);
        logic [OUT_W-1:0] h;
        h    = '0;
        h[a] = 1'b1;
        return (ACT_HIGH != 0) ? h : ~h;
    endfunction

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;
    logic [OUT_W-1:0]  z_q;
    logic [OUT_W-1:0]  z_d;
    logic              scan_req;

`ifdef DECODER_SCAN_EN
    logic              step_q;
    logic              step_d;
    logic [ADDR_W-1:0] idx_next;
    logic              tick_step;
    logic              scan_run;

    assign scan_req = mode;
    assign scan_run = (state_q == SCAN) && (state_d == SCAN);
    assign step     = step_q;

    scan_tick #(
        .TICK_DIV (TICK_DIV),
        .ADDR_W   (ADDR_W)
    ) u_scan_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (scan_run),
        .idx      (idx_q),
        .idx_next (idx_next),
        .step     (tick_step)
    );
`else
    logic        unused_mode;
    logic [15:0] unused_tick_div;

    assign scan_req        = 1'b0;
    assign unused_mode     = mode;
    assign unused_tick_div = 16'(TICK_DIV);
    assign step            = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else if (scan_req) begin
            state_d = SCAN;
        end else begin
            state_d = DIRECT;
        end
    end

    // Outputs are decoded from the destination state so z tracks idx with no extra stage
    always_comb begin
        idx_d = idx_q;
        z_d   = z_q;
`ifdef DECODER_SCAN_EN
        step_d = 1'b0;
`endif
        case (state_d)
            DIRECT: begin
                if (load) begin
                    idx_d = addr;
                    z_d   = decode(addr);
                end
            end
`ifdef DECODER_SCAN_EN
            SCAN: begin
                if (state_q != SCAN) begin
                    idx_d = '0;
                    z_d   = decode('0);
                end else begin
                    idx_d  = idx_next;
                    z_d    = decode(idx_next);
                    step_d = tick_step;
                end
            end
`endif
            default: begin
                idx_d = '0;
                z_d   = Z_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            z_q     <= Z_IDLE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            z_q     <= z_d;
        end
    end

`ifdef DECODER_SCAN_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step_d;
        end
    end
`endif

    assign z   = z_q;
    assign idx = idx_q;

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 SHALL provide parameter ADDR_W, default 3, meaning address width; output width is 2**ADDR_W.
REQ-002 SHALL provide parameter TICK_DIV, default 4, meaning clock cycles per scan step; legal range 1..65535.
REQ-003 SHALL provide parameter ACT_HIGH, default 1, meaning output polarity: 1 for active-high one-hot, 0 for active-low one-cold.
REQ-004 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL provide port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL provide port en  input  1  block enable.
REQ-007 SHALL provide port mode  input  1  0 for direct decode, 1 for auto-scan.
REQ-008 SHALL provide port load  input  1  direct-mode strobe qualifying addr.
REQ-009 SHALL provide port addr  input  ADDR_W  direct-mode address.
REQ-010 SHALL provide port z  output  2**ADDR_W  registered decoded outputs.
REQ-011 SHALL provide port idx  output  ADDR_W  index currently driven on z.
REQ-012 SHALL provide port step  output  1  one-cycle pulse when the scan index advances.

Function
REQ-013 SHALL implement states IDLE, DIRECT and SCAN.
REQ-014 SHALL take transitions at each edge: en=0 goes to IDLE; en=1 with mode=0 goes to DIRECT; en=1 with mode=1 goes to SCAN.
REQ-015 SHALL drive z all-inactive in IDLE and SHALL hold idx and the divider at 0.
REQ-016 SHALL, in DIRECT, register addr into idx when load=1; z then shows the one-hot of idx with 1-cycle latency from load.
REQ-017 SHALL, in DIRECT with load=0, hold z and idx unchanged.
REQ-018 SHALL, on entry to SCAN from any state, clear idx and the divider to 0; z shows bit 0 the cycle after entry.
REQ-019 SHALL, in SCAN, have the divider count 0..TICK_DIV-1; at terminal count idx increments, the divider clears and step pulses for exactly 1 cycle.
REQ-020 SHALL wrap idx from 2**ADDR_W-1 to 0 with no gap cycle.
REQ-021 SHALL ignore load in SCAN.
REQ-022 SHALL, with TICK_DIV=1, advance idx every cycle and hold step high continuously.
REQ-023 SHALL, on a SCAN to DIRECT switch, hold idx and z until the next load; if load=1 on the switch edge, addr wins.
REQ-024 SHALL have at most one z bit active in every cycle, with no glitch between steps.
REQ-025 SHALL keep step 0 outside SCAN.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, set the state to IDLE, z all-inactive (0s if ACT_HIGH=1, 1s if 0), idx=0, divider=0 and step=0.
REQ-027 SHALL give reset priority over en, mode and load; an in-progress scan is abandoned and restarts at idx 0 on the next SCAN entry.

Configuration
REQ-028 SHALL, with DECODER_SCAN_EN defined, include the SCAN state, the divider and step generation as specified.
REQ-029 SHALL, without DECODER_SCAN_EN, keep the mode port but ignore it (treated as 0), make SCAN unreachable, omit the divider, and tie step to 0; all other behaviour is unchanged.

Structure
REQ-030 SHALL place the state encoding typedef (IDLE, DIRECT, SCAN) and the onehot width function in shared package decoder_pkg.
REQ-031 SHALL implement the divider and index advance in sub-module scan_tick (parameters TICK_DIV, ADDR_W; outputs idx_next and step), instantiated only under DECODER_SCAN_EN.

Verification
REQ-032 SHALL cover: reset then en=1, mode=0, load=1, addr=5 -> next cycle z=8'b0010_0000, idx=5; load=0 -> z held.
REQ-033 SHALL cover: ACT_HIGH=0, addr=2 loaded -> z=8'b1111_1011.
REQ-034 SHALL cover: en=1, mode=1, TICK_DIV=4 -> z=01 for 4 cycles, then step pulse and z=02; after 32 cycles idx wraps 7->0 with step=1.
REQ-035 SHALL cover: mid-scan at idx=3, rst_n=0 for 1 cycle -> z=0, idx=0, step=0; then mode=1 -> scan restarts at bit 0.
REQ-036 SHALL cover: in SCAN at idx=6, switch mode=0 with load=1, addr=1 on the same edge -> z=8'b0000_0010, step=0.
REQ-037 SHALL cover: build without DECODER_SCAN_EN, mode=1, load=1, addr=4 -> z=8'b0001_0000, step stays 0.
